// File: rtl/module_mult_booth_ctrl.sv
// Radix-2 Booth multiplier sequencer.
// Steps the datapath through clear, load and N add/sub + shift iterations.
package mult_booth_pkg;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

endpackage

module module_mult_booth_ctrl
    import mult_booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ack,
    input  logic [1:0]    Q_LSB,
    output mult_control_t mult_control,
    output logic          dp_clear,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        OP,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // State and iteration-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and control decode (Mealy in OP)
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mult_control = '0;
        dp_clear     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                dp_clear = 1'b1;
                state_d  = LOAD;
            end

            LOAD: begin
                mult_control.load_A = 1'b1;
                mult_control.load_B = 1'b1;
                cnt_d               = CW'(N);
                state_d             = OP;
            end

            OP: begin
                // {LQ[0],Q_1}: 01 adds M, 10 subtracts M, 00/11 skip
                unique case (Q_LSB)
                    2'b01: begin
                        mult_control.load_add = 1'b1;
                        mult_control.add_sub  = 1'b1;
                    end
                    2'b10: begin
                        mult_control.load_add = 1'b1;
                    end
                    default: begin
                    end
                endcase
                state_d = SHIFT;
            end

            SHIFT: begin
                mult_control.shift_HQ_LQ_Q_1 = 1'b1;
                cnt_d = cnt_q - CW'(1);
                // last iteration leaves cnt at 0 and never wraps
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = OP;
                end
            end

            DONE: begin
                done = 1'b1;
                if (ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_module_mult_booth_ctrl.sv
// Bench for the Booth sequencer with a behavioural datapath (N=8).
// Scoreboard of expected products, popped by a monitor on done rise.
module tb_module_mult_booth_ctrl;
    import mult_booth_pkg::*;

    localparam int N   = 8;
    localparam int LAT = 2 * N + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ack;
    logic [1:0]    Q_LSB;
    mult_control_t mc;
    logic          dp_clear;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    module_mult_booth_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ack          (ack),
        .Q_LSB        (Q_LSB),
        .mult_control (mc),
        .dp_clear     (dp_clear),
        .busy         (busy),
        .done         (done)
    );

    // Behavioural Booth datapath: M = multiplicand, {HQ,LQ,Q_1} shifter
    logic [N-1:0] A_in;
    logic [N-1:0] B_in;
    logic [N-1:0] M_q;
    logic [N-1:0] HQ_q;
    logic [N-1:0] LQ_q;
    logic         Q1_q;
    logic [2*N-1:0] Y;

    assign Q_LSB = {LQ_q[0], Q1_q};
    assign Y     = {HQ_q, LQ_q};

    always_ff @(posedge clk) begin
        if (rst || dp_clear) begin
            M_q  <= '0;
            HQ_q <= '0;
            LQ_q <= '0;
            Q1_q <= 1'b0;
        end else begin
            if (mc.load_A) M_q <= A_in;
            if (mc.load_B) LQ_q <= B_in;
            if (mc.shift_HQ_LQ_Q_1) begin
                {HQ_q, LQ_q, Q1_q} <= {HQ_q[N-1], HQ_q, LQ_q};
            end else if (mc.load_add) begin
                HQ_q <= mc.add_sub ? HQ_q + M_q : HQ_q - M_q;
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    logic [15:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: invariants every cycle, result/latency on done rise
    bit busy_p = 1'b0;
    bit done_p = 1'b0;
    int e0     = 0;
    int shifts = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] op_exp;
            if (mc.shift_HQ_LQ_Q_1)
                check("shift_excl", 32'({mc.load_A, mc.load_B, mc.load_add}), 32'd0);
            check("ldA_eq_ldB", 32'(mc.load_A), 32'(mc.load_B));
            if (dp_clear)
                check("clear_alone", 32'(mc), 32'd0);
            if (!busy)
                check("idle_outs", 32'({mc, dp_clear, done}), 32'd0);
            if (done)
                check("done_ctrl", 32'({mc, dp_clear}), 32'd0);
            if (busy && !done && !dp_clear && !mc.load_A && !mc.shift_HQ_LQ_Q_1) begin
                case (Q_LSB)
                    2'b01:   op_exp = 2'b11;
                    2'b10:   op_exp = 2'b10;
                    default: op_exp = 2'b00;
                endcase
                check("op_decode", 32'({mc.load_add, mc.add_sub}), 32'(op_exp));
            end
            if (busy && !busy_p) begin
                e0     = edge_cnt;
                shifts = 0;
            end
            if (mc.shift_HQ_LQ_Q_1) shifts++;
            if (done && !done_p) begin
                check("latency", 32'(edge_cnt - e0 + 1), 32'(LAT));
                check("shift_cnt", 32'(shifts), 32'(N));
                if (exp_q.size() == 0)
                    check("sb_nonempty", 32'(exp_q.size()), 32'd1);
                else
                    check("Y", 32'(Y), 32'(exp_q.pop_front()));
            end
        end
        busy_p = busy;
        done_p = done;
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [15:0] y);
        A_in = a;
        B_in = b;
        exp_q.push_back(y);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            check("busy_run", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic mult(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [15:0] y);
        issue(a, b, y);
        wait_done();
        do_ack();
    endtask

    initial begin
        logic [15:0] y0;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int p;

        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        A_in  = '0;
        B_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'({mc, dp_clear, busy, done}), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", 32'(busy), 32'd0);

        // basic product and fixed latency
        mult(8'd3, 8'd5, 16'h000F);

        // signed vectors; a stray ack mid-run must be ignored
        issue(8'hF9, 8'd6, 16'hFFD6);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ack_ignored", 32'(busy), 32'd1);
        wait_done();
        do_ack();
        mult(8'd5, 8'hFD, 16'hFFF1);
        mult(8'd0, 8'h80, 16'h0000);

        // hold in DONE, stray start ignored, ack returns to IDLE
        issue(8'd7, 8'd9, 16'h003F);
        wait_done();
        y0 = Y;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(posedge clk); #1;
            check("hold_done", 32'(done), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_Y", 32'(Y), 32'(y0));
        end
        start = 1'b0;
        do_ack();
        check("ack_idle_busy", 32'(busy), 32'd0);
        check("ack_idle_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("no_restart", 32'(busy), 32'd0);

        // reset during the 4th OP cycle aborts without a done
        A_in  = 8'h7F;
        B_in  = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outs", 32'({mc, dp_clear, busy, done}), 32'd0);
        mult(8'd2, 8'd2, 16'h0004);

        // back-to-back random in-range operands
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (ra == 8'h80) ra = 8'h81;
            p = $signed(ra) * $signed(rb);
            mult(ra, rb, p[15:0]);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
